// File: rtl/pht_access_ctrl_pkg.sv
// Shared types, sizes and entry layout for the PHT single-port access controller.
package pht_access_ctrl_pkg;

    localparam int PHT_NUMS   = 256;
    localparam int INDEX_W    = 8;
    localparam int DATA_WIDTH = 56;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int STARVE_MAX = 8;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    // Entry layout: {count[1:0], tag[21:0], target[31:0]}
    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = 32;
    localparam int TAG_LSB    = 32;
    localparam int TAG_W      = 22;
    localparam int COUNT_LSB  = 54;
    localparam int COUNT_W    = 2;

    typedef enum logic [1:0] {
        W_TAKEN  = 2'b00,
        S_TAKEN  = 2'b01,
        WN_TAKEN = 2'b10,
        SN_TAKEN = 2'b11
    } pht_count_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    typedef logic [INDEX_W-1:0]    pht_index_t;
    typedef logic [DATA_WIDTH-1:0] pht_data_t;

    localparam pht_data_t INIT_DATA = {SN_TAKEN, {TAG_W{1'b0}}, {TARGET_W{1'b0}}};

    function automatic pht_data_t make_entry(pht_count_e cnt, logic [TAG_W-1:0] tag,
                                             logic [TARGET_W-1:0] target);
        return {cnt, tag, target};
    endfunction

endpackage

// File: rtl/pht_access_ctrl_if.sv
// Fetch lookup, update handshake and RAM port bundle of the PHT access controller.
interface pht_access_ctrl_if;
    import pht_access_ctrl_pkg::*;

    logic             rd_req;
    pht_index_t       rd_index;
    logic             rd_grant;
    pht_data_t        rd_data;
    logic             upd_valid;
    pht_index_t       upd_index;
    pht_data_t        upd_data;
    logic             upd_ready;
    logic             ram_we;
    pht_index_t       ram_addr;
    pht_data_t        ram_wdata;
    pht_data_t        ram_rdata;
    logic             init_done;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  rd_req, rd_index, upd_valid, upd_index, upd_data, ram_rdata,
        output rd_grant, rd_data, upd_ready, ram_we, ram_addr, ram_wdata,
               init_done, fifo_count
    );

    modport master (
        output rd_req, rd_index, upd_valid, upd_index, upd_data, ram_rdata,
        input  rd_grant, rd_data, upd_ready, ram_we, ram_addr, ram_wdata,
               init_done, fifo_count
    );

endinterface

// File: rtl/pht_access_ctrl_upd_fifo.sv
// Circular update buffer; exposes the head plus an oldest-first view for forwarding.
module pht_upd_fifo
    import pht_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  pht_index_t            push_index,
    input  pht_data_t             push_data,
    input  logic                  pop,
    output pht_index_t            head_index,
    output pht_data_t             head_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output pht_index_t            view_index [FIFO_DEPTH],
    output pht_data_t             view_data  [FIFO_DEPTH],
    output logic [FIFO_DEPTH-1:0] view_valid
);

    pht_index_t       idx_mem  [FIFO_DEPTH];
    pht_data_t        data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset: only slots below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr]  <= push_index;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            view_index[k] = idx_mem[rd_ptr + PTR_W'(k)];
            view_data[k]  = data_mem[rd_ptr + PTR_W'(k)];
            view_valid[k] = (CNT_W'(k) < count_q);
        end
    end

    assign head_index = idx_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign count      = count_q;
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/pht_access_ctrl.sv
// Shares the single PHT RAM port between fetch lookups and buffered predictor updates,
// after a post-reset sweep that writes INIT_DATA into every entry.
module pht_access_ctrl
    import pht_access_ctrl_pkg::*;
(
    input logic              clk,
    input logic              resetn,
    pht_access_ctrl_if.slave bus
);

    ctrl_state_e         state;
    pht_index_t          sweep_ptr;
    logic [STARVE_W-1:0] starve;
    logic                init_done_q;

    logic                run;
    logic                upd_ready;
    logic                push;
    logic                wr_sel;
    pht_index_t          head_index;
    pht_data_t           head_data;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    pht_index_t          view_index [FIFO_DEPTH];
    pht_data_t           view_data  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] view_valid;
    logic                fwd_hit;
    pht_data_t           fwd_data;

    assign run       = (state == ST_RUN);
    assign upd_ready = run & ~full;
    assign push      = bus.upd_valid & upd_ready;
    assign wr_sel    = run & ~empty &
                       (~bus.rd_req | full | (starve == STARVE_W'(STARVE_MAX)));

    pht_upd_fifo u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_index (bus.upd_index),
        .push_data  (bus.upd_data),
        .pop        (wr_sel),
        .head_index (head_index),
        .head_data  (head_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .view_index (view_index),
        .view_data  (view_data),
        .view_valid (view_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_INIT;
            sweep_ptr   <= '0;
            starve      <= '0;
            init_done_q <= 1'b0;
        end else if (state == ST_INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == INDEX_W'(PHT_NUMS - 1)) begin
                state       <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end else begin
            if (empty || wr_sel)
                starve <= '0;
            else if (bus.rd_req && starve != STARVE_W'(STARVE_MAX))
                starve <= starve + 1'b1;
        end
    end

    // Write enable is gated by reset so a held reset never scribbles on the RAM.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = bus.rd_index;
        bus.ram_wdata = '0;
        bus.rd_grant  = 1'b0;
        if (!run) begin
            bus.ram_we    = resetn;
            bus.ram_addr  = sweep_ptr;
            bus.ram_wdata = INIT_DATA;
        end else if (wr_sel) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = head_index;
            bus.ram_wdata = head_data;
        end else begin
            bus.rd_grant  = bus.rd_req;
        end
    end

    // Scan oldest to youngest so the youngest matching update wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (view_valid[k] && view_index[k] == bus.rd_index) begin
                fwd_hit  = 1'b1;
                fwd_data = view_data[k];
            end
        end
    end

    assign bus.rd_data    = fwd_hit ? fwd_data : bus.ram_rdata;
    assign bus.upd_ready  = upd_ready;
    assign bus.init_done  = init_done_q;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Self-checking bench for pht_access_ctrl: queue-based reference model, vector table
// and directed sequences for the starvation, forwarding and reset corner cases.
module tb_pht_access_ctrl;
    import pht_access_ctrl_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    pht_access_ctrl_if bus();

    pht_access_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    pht_data_t ram [PHT_NUMS];
    always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    assign bus.ram_rdata = ram[bus.ram_addr];

    typedef struct {
        pht_index_t idx;
        pht_data_t  data;
    } upd_t;

    typedef struct {
        bit         rq;
        pht_index_t ri;
        bit         uv;
        pht_index_t ui;
        bit         e_grant;
        bit         e_we;
        pht_index_t e_addr;
        int         e_count;
        bit         e_ready;
    } vec_t;

    upd_t      mq[$];
    int        m_starve;
    bit        m_run;
    int        m_sweep;
    bit        m_wr;
    pht_data_t m_pht [PHT_NUMS];

    bit         cur_rq;
    pht_index_t cur_ri;
    bit         cur_uv;
    pht_index_t cur_ui;
    pht_data_t  cur_ud;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic pht_data_t lookup_ref(pht_index_t idx);
        pht_data_t r = m_pht[idx];
        foreach (mq[i]) if (mq[i].idx == idx) r = mq[i].data;
        return r;
    endfunction

    function automatic pht_data_t rand_entry();
        return make_entry(pht_count_e'($urandom_range(0, 3)), TAG_W'($urandom), $urandom);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_run    = 1'b0;
        m_sweep  = 0;
    endtask

    // Drive one cycle's inputs, let logic settle, compare against the model.
    task automatic apply_stimulus(input bit rq, input pht_index_t ri, input bit uv,
                                  input pht_index_t ui, input pht_data_t ud);
        bit         e_we, e_grant, e_ready, e_done;
        pht_index_t e_addr;
        pht_data_t  e_wdata;
        int         sz;
        cur_rq = rq; cur_ri = ri; cur_uv = uv; cur_ui = ui; cur_ud = ud;
        bus.rd_req    = rq;
        bus.rd_index  = ri;
        bus.upd_valid = uv;
        bus.upd_index = ui;
        bus.upd_data  = ud;
        #1;
        sz = mq.size();
        m_wr = 1'b0;
        if (!m_run) begin
            e_we = 1'b1; e_addr = pht_index_t'(m_sweep); e_wdata = INIT_DATA;
            e_grant = 1'b0; e_ready = 1'b0; e_done = 1'b0;
        end else begin
            e_done  = 1'b1;
            e_ready = (sz < FIFO_DEPTH);
            m_wr    = (sz > 0) && (!rq || sz == FIFO_DEPTH || m_starve == STARVE_MAX);
            e_we    = m_wr;
            e_addr  = m_wr ? mq[0].idx : ri;
            e_wdata = m_wr ? mq[0].data : '0;
            e_grant = !m_wr && rq;
        end
        check_output("ram_we", 64'(bus.ram_we), 64'(e_we));
        check_output("ram_addr", 64'(bus.ram_addr), 64'(e_addr));
        check_output("rd_grant", 64'(bus.rd_grant), 64'(e_grant));
        check_output("upd_ready", 64'(bus.upd_ready), 64'(e_ready));
        check_output("init_done", 64'(bus.init_done), 64'(e_done));
        check_output("fifo_count", 64'(bus.fifo_count), 64'(m_run ? sz : 0));
        if (e_we)    check_output("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
        if (e_grant) check_output("rd_data", 64'(bus.rd_data), 64'(lookup_ref(ri)));
    endtask

    // Commit the cycle's effects to the model and move to the next sampling point.
    task automatic advance();
        if (!m_run) begin
            m_pht[m_sweep] = INIT_DATA;
            m_sweep++;
            if (m_sweep == PHT_NUMS) m_run = 1'b1;
        end else begin
            bit was_full = (mq.size() == FIFO_DEPTH);
            bit was_empty = (mq.size() == 0);
            if (m_wr) begin
                m_pht[mq[0].idx] = mq[0].data;
                void'(mq.pop_front());
                m_starve = 0;
            end else if (was_empty) begin
                m_starve = 0;
            end else if (cur_rq && m_starve < STARVE_MAX) begin
                m_starve++;
            end
            if (cur_uv && !was_full) mq.push_back('{cur_ui, cur_ud});
        end
        @(negedge clk);
    endtask

    vec_t tbl [10];

    initial begin
        pht_data_t da, db;
        int  grants;
        bit  found;

        bus.rd_req = 1'b1; bus.rd_index = '0; bus.upd_valid = 1'b1;
        bus.upd_index = '0; bus.upd_data = '0;
        #1 resetn = 1'b0;
        #22;
        check_output("reset_init_done", 64'(bus.init_done), 64'd0);
        check_output("reset_upd_ready", 64'(bus.upd_ready), 64'd0);
        check_output("reset_rd_grant", 64'(bus.rd_grant), 64'd0);
        check_output("reset_ram_we", 64'(bus.ram_we), 64'd0);
        check_output("reset_fifo_count", 64'(bus.fifo_count), 64'd0);

        @(negedge clk);
        resetn = 1'b1;
        model_reset();

        $display("[TB] init sweep");
        for (int i = 0; i <= PHT_NUMS; i++) begin
            apply_stimulus(1'b1, pht_index_t'(i), 1'b0, '0, '0);
            if (i == PHT_NUMS - 1) check_output("sweep_last_addr", 64'(bus.ram_addr), 64'hFF);
            if (i == PHT_NUMS) begin
                check_output("init_done_257", 64'(bus.init_done), 64'd1);
                check_output("ready_after_init", 64'(bus.upd_ready), 64'd1);
            end
            advance();
        end

        $display("[TB] starvation limit");
        apply_stimulus(1'b1, 8'h05, 1'b1, 8'h12, rand_entry());
        advance();
        grants = 0;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            apply_stimulus(1'b1, pht_index_t'($urandom_range(0, 15)), 1'b0, '0, '0);
            if (bus.ram_we) begin
                found = 1'b1;
                check_output("starve_write_addr", 64'(bus.ram_addr), 64'h12);
                check_output("starve_write_grant", 64'(bus.rd_grant), 64'd0);
            end else if (bus.rd_grant) begin
                grants++;
            end
            advance();
        end
        check_output("starve_write_seen", 64'(found), 64'd1);
        check_output("starve_grant_count", 64'(grants), 64'd8);

        $display("[TB] fill / forced write / drain table");
        tbl[0] = '{1'b1, 8'h80, 1'b1, 8'h21, 1'b1, 1'b0, 8'h80, 0, 1'b1};
        tbl[1] = '{1'b1, 8'h80, 1'b1, 8'h22, 1'b1, 1'b0, 8'h80, 1, 1'b1};
        tbl[2] = '{1'b1, 8'h80, 1'b1, 8'h23, 1'b1, 1'b0, 8'h80, 2, 1'b1};
        tbl[3] = '{1'b1, 8'h80, 1'b1, 8'h24, 1'b1, 1'b0, 8'h80, 3, 1'b1};
        tbl[4] = '{1'b1, 8'h80, 1'b1, 8'h25, 1'b0, 1'b1, 8'h21, 4, 1'b0};
        tbl[5] = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 3, 1'b1};
        tbl[6] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3, 1'b1};
        tbl[7] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 8'h23, 2, 1'b1};
        tbl[8] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 8'h24, 1, 1'b1};
        tbl[9] = '{1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 0, 1'b1};
        for (int v = 0; v < 10; v++) begin
            apply_stimulus(tbl[v].rq, tbl[v].ri, tbl[v].uv, tbl[v].ui, rand_entry());
            check_output($sformatf("vec%0d_grant", v), 64'(bus.rd_grant), 64'(tbl[v].e_grant));
            check_output($sformatf("vec%0d_we", v), 64'(bus.ram_we), 64'(tbl[v].e_we));
            check_output($sformatf("vec%0d_addr", v), 64'(bus.ram_addr), 64'(tbl[v].e_addr));
            check_output($sformatf("vec%0d_count", v), 64'(bus.fifo_count), 64'(tbl[v].e_count));
            check_output($sformatf("vec%0d_ready", v), 64'(bus.upd_ready), 64'(tbl[v].e_ready));
            advance();
        end

        $display("[TB] forwarding");
        da = rand_entry();
        db = rand_entry();
        apply_stimulus(1'b1, 8'h40, 1'b1, 8'h40, da);
        check_output("fwd_empty_grant", 64'(bus.rd_grant), 64'd1);
        check_output("fwd_same_cycle_a", 64'(bus.rd_data), 64'(INIT_DATA));
        advance();
        apply_stimulus(1'b1, 8'h40, 1'b1, 8'h40, db);
        check_output("fwd_same_cycle_b", 64'(bus.rd_data), 64'(da));
        advance();
        apply_stimulus(1'b1, 8'h40, 1'b0, '0, '0);
        check_output("fwd_youngest", 64'(bus.rd_data), 64'(db));
        advance();
        for (int d = 0; d < 2; d++) begin
            apply_stimulus(1'b0, 8'h40, 1'b0, '0, '0);
            advance();
        end
        apply_stimulus(1'b1, 8'h40, 1'b0, '0, '0);
        check_output("ram_after_drain_grant", 64'(bus.rd_grant), 64'd1);
        check_output("ram_after_drain_rdata", 64'(bus.ram_rdata), 64'(db));
        check_output("ram_after_drain_data", 64'(bus.rd_data), 64'(db));
        advance();

        $display("[TB] random traffic");
        for (int r = 0; r < 800; r++) begin
            int pct = (r < 400) ? 9 : 5;
            apply_stimulus($urandom_range(0, 9) < pct,
                           pht_index_t'(8'h40 + $urandom_range(0, 7)),
                           $urandom_range(0, 1) == 1,
                           pht_index_t'(8'h40 + $urandom_range(0, 7)),
                           rand_entry());
            advance();
        end

        $display("[TB] reset mid-run");
        for (int d = 0; d < FIFO_DEPTH + 2; d++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, '0, '0);
            advance();
        end
        apply_stimulus(1'b1, 8'h10, 1'b1, 8'h30, rand_entry());
        advance();
        apply_stimulus(1'b1, 8'h11, 1'b1, 8'h31, rand_entry());
        advance();
        apply_stimulus(1'b1, 8'h12, 1'b0, '0, '0);
        check_output("pre_reset_count", 64'(bus.fifo_count), 64'd2);
        #2 resetn = 1'b0;
        #1;
        check_output("async_reset_count", 64'(bus.fifo_count), 64'd0);
        check_output("async_reset_init_done", 64'(bus.init_done), 64'd0);
        check_output("async_reset_ready", 64'(bus.upd_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < PHT_NUMS + 40; i++) begin
            apply_stimulus($urandom_range(0, 1) == 1, pht_index_t'($urandom_range(0, 3)),
                           $urandom_range(0, 1) == 1, pht_index_t'($urandom_range(0, 3)),
                           rand_entry());
            if (i == 0) check_output("sweep_restart_addr", 64'(bus.ram_addr), 64'd0);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
